n64_cfg: RTL and testbench

- Configuration register bank for the N64 PI register window at address[16]=1.
- Sits directly downstream of the unlock sequencer and is gated by its cfg_unlock output.
- Exposes STATUS/CMD, DATA0, DATA1 and IDENTIFIER registers to the N64 host.
- Hands host commands to the controller MCU through a valid/ack/done handshake and raises irq when a command completes.

---
 rtl/n64_cfg_if.sv | 29 ++
 rtl/n64_cfg.sv | 125 ++++++++++++
 tb/tb_n64_cfg.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/n64_cfg_if.sv
// Host register bus and MCU command handshake for the n64_cfg register bank.
interface n64_cfg_if;
  logic [16:0] reg_address;
  logic        reg_read;
  logic        reg_write;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        cmd_valid;
  logic [7:0]  cmd_id;
  logic [31:0] cmd_arg0;
  logic [31:0] cmd_arg1;
  logic        cmd_ack;
  logic        cmd_done;
  logic        cmd_error;
  logic [31:0] rsp_data0;
  logic [31:0] rsp_data1;

  modport slave (
    input  reg_address, reg_read, reg_write, reg_wdata,
    input  cmd_ack, cmd_done, cmd_error, rsp_data0, rsp_data1,
    output reg_rdata, cmd_valid, cmd_id, cmd_arg0, cmd_arg1
  );

  modport master (
    output reg_address, reg_read, reg_write, reg_wdata,
    output cmd_ack, cmd_done, cmd_error, rsp_data0, rsp_data1,
    input  reg_rdata, cmd_valid, cmd_id, cmd_arg0, cmd_arg1
  );
endinterface

// File: rtl/n64_cfg.sv
// N64 PI configuration window: STATUS/CMD, DATA0, DATA1, IDENTIFIER registers
// with a valid/ack/done command handoff to the controller MCU.
module n64_cfg #(
  parameter logic [31:0] ID_VALUE = 32'h53437632
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_unlock,
  input  logic       n64_reset,
  input  logic       n64_nmi,
  n64_cfg_if.slave   bus,
  output logic       irq
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t      state_q;
  logic        cmd_valid_q;
  logic [7:0]  cmd_id_q;
  logic [31:0] data0_q;
  logic [31:0] data1_q;
  logic        error_q;
  logic        irq_q;
  logic [15:0] rdata_q;

  logic        busy;
  logic        hit;
  logic        lo;
  logic [1:0]  word;
  logic        wr_en;
  logic        abort;
  logic [15:0] rd_val;

  assign busy  = (state_q != S_IDLE);
  assign hit   = bus.reg_address[16] && (bus.reg_address[15:2] < 14'd4);
  assign word  = bus.reg_address[3:2];
  assign lo    = bus.reg_address[1];
  assign wr_en = bus.reg_write && cfg_unlock && hit;
  assign abort = n64_reset || n64_nmi;

  always_comb begin
    rd_val = '0;
    if (cfg_unlock && hit) begin
      case (word)
        2'd0:    rd_val = lo ? {8'd0, cmd_id_q} : {busy, error_q, irq_q, 13'd0};
        2'd1:    rd_val = lo ? data0_q[15:0] : data0_q[31:16];
        2'd2:    rd_val = lo ? data1_q[15:0] : data1_q[31:16];
        default: rd_val = lo ? ID_VALUE[15:0] : ID_VALUE[31:16];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_id_q    <= '0;
      data0_q     <= '0;
      data1_q     <= '0;
      error_q     <= 1'b0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      if (bus.reg_read) rdata_q <= rd_val;

      if (abort) begin
        state_q     <= S_IDLE;
        cmd_valid_q <= 1'b0;
        error_q     <= 1'b0;
        irq_q       <= 1'b0;
      end else begin
        if (wr_en) begin
          case (word)
            2'd0: begin
              if (!lo) begin
                if (bus.reg_wdata[13]) irq_q <= 1'b0;
              end else if (!busy) begin
                cmd_id_q    <= bus.reg_wdata[7:0];
                error_q     <= 1'b0;
                irq_q       <= 1'b0;
                state_q     <= S_REQ;
                cmd_valid_q <= 1'b1;
              end
            end
            2'd1: if (!busy) begin
              if (lo) data0_q[15:0] <= bus.reg_wdata;
              else    data0_q[31:16] <= bus.reg_wdata;
            end
            2'd2: if (!busy) begin
              if (lo) data1_q[15:0] <= bus.reg_wdata;
              else    data1_q[31:16] <= bus.reg_wdata;
            end
            default: ;
          endcase
        end

        // Completion comes after the register writes so its irq set beats a host clear.
        case (state_q)
          S_REQ, S_WAIT: begin
            if (bus.cmd_done) begin
              state_q     <= S_IDLE;
              cmd_valid_q <= 1'b0;
              data0_q     <= bus.rsp_data0;
              data1_q     <= bus.rsp_data1;
              error_q     <= bus.cmd_error;
              irq_q       <= 1'b1;
            end else if (state_q == S_REQ && bus.cmd_ack) begin
              state_q     <= S_WAIT;
              cmd_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.reg_rdata = rdata_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_id    = cmd_id_q;
  assign bus.cmd_arg0  = data0_q;
  assign bus.cmd_arg1  = data1_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_n64_cfg.sv
// Directed self-checking bench for n64_cfg.
module tb_n64_cfg;

  logic clk = 1'b0;
  logic reset;
  logic cfg_unlock;
  logic n64_reset;
  logic n64_nmi;
  logic irq;

  n64_cfg_if bus ();

  n64_cfg #(.ID_VALUE(32'h53437632)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_unlock (cfg_unlock),
    .n64_reset  (n64_reset),
    .n64_nmi    (n64_nmi),
    .bus        (bus.slave),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] A_STAT_HI = 17'h10000;
  localparam logic [16:0] A_STAT_LO = 17'h10002;
  localparam logic [16:0] A_D0_HI   = 17'h10004;
  localparam logic [16:0] A_D0_LO   = 17'h10006;
  localparam logic [16:0] A_D1_HI   = 17'h10008;
  localparam logic [16:0] A_D1_LO   = 17'h1000A;
  localparam logic [16:0] A_ID_HI   = 17'h1000C;
  localparam logic [16:0] A_ID_LO   = 17'h1000E;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [16:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.reg_address = a;
    bus.reg_wdata   = d;
    bus.reg_write   = 1'b1;
    @(negedge clk);
    bus.reg_write   = 1'b0;
  endtask

  task automatic rd(input logic [16:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.reg_address = a;
    bus.reg_read    = 1'b1;
    @(negedge clk);
    bus.reg_read    = 1'b0;
    d = bus.reg_rdata;
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.cmd_ack = 1'b1;
    @(negedge clk);
    bus.cmd_ack = 1'b0;
  endtask

  task automatic done_pulse(input logic err, input logic [31:0] r0, input logic [31:0] r1);
    @(negedge clk);
    bus.cmd_done  = 1'b1;
    bus.cmd_error = err;
    bus.rsp_data0 = r0;
    bus.rsp_data1 = r1;
    @(negedge clk);
    bus.cmd_done  = 1'b0;
    bus.cmd_error = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_unlock = 1'b0; n64_reset = 1'b0; n64_nmi = 1'b0;
    bus.reg_address = '0; bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_wdata = '0;
    bus.cmd_ack = 1'b0; bus.cmd_done = 1'b0; bus.cmd_error = 1'b0;
    bus.rsp_data0 = '0; bus.rsp_data1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("rst_irq",   {31'd0, irq}, 32'd0);
    chk("rst_rdata", {16'd0, bus.reg_rdata}, 32'd0);
    chk("rst_cmdid", {24'd0, bus.cmd_id}, 32'd0);
    reset = 1'b1;

    // Identifier, locked and unlocked
    cfg_unlock = 1'b1;
    rd(A_ID_HI, rv); chk("id_hi", {16'd0, rv}, 32'h5343);
    rd(A_ID_LO, rv); chk("id_lo", {16'd0, rv}, 32'h7632);
    repeat (3) @(negedge clk);
    chk("rdata_hold", {16'd0, bus.reg_rdata}, 32'h7632);
    cfg_unlock = 1'b0;
    rd(A_ID_HI, rv); chk("id_hi_locked", {16'd0, rv}, 32'h0);
    rd(A_ID_LO, rv); chk("id_lo_locked", {16'd0, rv}, 32'h0);
    wr(A_D0_HI, 16'hFFFF);
    chk("locked_wr", bus.cmd_arg0, 32'h0);
    cfg_unlock = 1'b1;

    // Out-of-window addresses
    rd(17'h10010, rv); chk("oob_word4", {16'd0, rv}, 32'h0);
    rd(17'h0000C, rv); chk("oob_a16", {16'd0, rv}, 32'h0);

    // Issue command A5
    wr(A_D0_HI, 16'h1234);
    wr(A_D0_LO, 16'h5678);
    wr(A_D1_HI, 16'h0BAD);
    wr(A_D1_LO, 16'hF00D);
    wr(A_STAT_LO, 16'h00A5);
    chk("req_valid", {31'd0, bus.cmd_valid}, 32'd1);
    chk("req_id",    {24'd0, bus.cmd_id}, 32'hA5);
    chk("req_arg0",  bus.cmd_arg0, 32'h12345678);
    chk("req_arg1",  bus.cmd_arg1, 32'h0BADF00D);
    rd(A_STAT_HI, rv); chk("stat_busy", {16'd0, rv}, 32'h8000);

    // Writes while busy are dropped
    wr(A_STAT_LO, 16'h0011);
    wr(A_D1_HI, 16'hFFFF);
    chk("busy_cmdid", {24'd0, bus.cmd_id}, 32'hA5);
    chk("busy_arg1",  bus.cmd_arg1, 32'h0BADF00D);
    rd(A_STAT_LO, rv); chk("stat_lo", {16'd0, rv}, 32'h00A5);

    ack_pulse();
    chk("ack_valid", {31'd0, bus.cmd_valid}, 32'd0);
    rd(A_STAT_HI, rv); chk("wait_busy", {16'd0, rv}, 32'h8000);
    done_pulse(1'b1, 32'hDEADBEEF, 32'hCAFEF00D);
    chk("done_irq", {31'd0, irq}, 32'd1);
    rd(A_STAT_HI, rv); chk("done_stat", {16'd0, rv}, 32'h6000);
    rd(A_D0_HI, rv);   chk("done_d0hi", {16'd0, rv}, 32'hDEAD);
    rd(A_D0_LO, rv);   chk("done_d0lo", {16'd0, rv}, 32'hBEEF);
    chk("done_arg1", bus.cmd_arg1, 32'hCAFEF00D);

    wr(A_STAT_HI, 16'h2000);
    chk("irq_clr", {31'd0, irq}, 32'd0);
    rd(A_STAT_HI, rv); chk("err_kept", {16'd0, rv}, 32'h4000);

    // Ack and done together while in REQ
    wr(A_STAT_LO, 16'h003C);
    @(negedge clk);
    bus.cmd_ack = 1'b1; bus.cmd_done = 1'b1;
    bus.rsp_data0 = 32'h11112222; bus.rsp_data1 = 32'h33334444;
    @(negedge clk);
    bus.cmd_ack = 1'b0; bus.cmd_done = 1'b0;
    chk("ackdone_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("ackdone_irq",   {31'd0, irq}, 32'd1);
    chk("ackdone_arg0",  bus.cmd_arg0, 32'h11112222);
    rd(A_STAT_HI, rv); chk("ackdone_stat", {16'd0, rv}, 32'h2000);

    // Host irq clear coinciding with completion: set wins
    wr(A_STAT_LO, 16'h0055);
    chk("c55_irq_cleared", {31'd0, irq}, 32'd0);
    @(negedge clk);
    bus.reg_address = A_STAT_HI; bus.reg_wdata = 16'h2000; bus.reg_write = 1'b1;
    bus.cmd_done = 1'b1; bus.rsp_data0 = 32'h55550000; bus.rsp_data1 = 32'h0;
    @(negedge clk);
    bus.reg_write = 1'b0; bus.cmd_done = 1'b0;
    chk("set_wins_irq", {31'd0, irq}, 32'd1);

    // NMI in WAIT aborts; later done ignored
    wr(A_STAT_LO, 16'h0066);
    ack_pulse();
    @(negedge clk);
    n64_nmi = 1'b1;
    @(negedge clk);
    n64_nmi = 1'b0;
    chk("nmi_irq", {31'd0, irq}, 32'd0);
    rd(A_STAT_HI, rv); chk("nmi_stat", {16'd0, rv}, 32'h0000);
    chk("nmi_cmdid", {24'd0, bus.cmd_id}, 32'h66);
    done_pulse(1'b1, 32'hAAAAAAAA, 32'hBBBBBBBB);
    chk("late_done_irq",  {31'd0, irq}, 32'd0);
    chk("late_done_arg0", bus.cmd_arg0, 32'h55550000);

    // Abort beats a simultaneous command write
    @(negedge clk);
    n64_reset = 1'b1;
    bus.reg_address = A_STAT_LO; bus.reg_wdata = 16'h0077; bus.reg_write = 1'b1;
    @(negedge clk);
    n64_reset = 1'b0; bus.reg_write = 1'b0;
    chk("abort_wr_id",    {24'd0, bus.cmd_id}, 32'h66);
    chk("abort_wr_valid", {31'd0, bus.cmd_valid}, 32'd0);

    // Asynchronous reset mid-REQ
    wr(A_STAT_LO, 16'h0088);
    chk("pre_rst_valid", {31'd0, bus.cmd_valid}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("arst_cmdid", {24'd0, bus.cmd_id}, 32'd0);
    chk("arst_rdata", {16'd0, bus.reg_rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    rd(A_STAT_HI, rv); chk("post_stat_hi", {16'd0, rv}, 32'h0);
    rd(A_STAT_LO, rv); chk("post_stat_lo", {16'd0, rv}, 32'h0);
    rd(A_D0_HI, rv);   chk("post_d0hi", {16'd0, rv}, 32'h0);
    rd(A_D0_LO, rv);   chk("post_d0lo", {16'd0, rv}, 32'h0);
    rd(A_D1_HI, rv);   chk("post_d1hi", {16'd0, rv}, 32'h0);
    rd(A_D1_LO, rv);   chk("post_d1lo", {16'd0, rv}, 32'h0);
    rd(A_ID_HI, rv);   chk("post_id_hi", {16'd0, rv}, 32'h5343);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
